// File: rtl/mux4_1_sync.sv
// rtl/mux4_1_sync.sv - 4:1 lane multiplexer with combinational and registered outputs
module mux4_1_sync #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           sel,
    input  logic [4*WIDTH-1:0]   in,
    output logic [WIDTH-1:0]     out,
    output logic [WIDTH-1:0]     out_q,
    output logic                 out_valid
);

    logic [WIDTH-1:0] w_lane;
    logic [WIDTH-1:0] r_out_q;
    logic             r_out_valid;

    // An X/Z select matches no item and falls through to an X result.
    always_comb begin
        w_lane = 'x;
        case (sel)
            2'b00:   w_lane = in[0*WIDTH +: WIDTH];
            2'b01:   w_lane = in[1*WIDTH +: WIDTH];
            2'b10:   w_lane = in[2*WIDTH +: WIDTH];
            2'b11:   w_lane = in[3*WIDTH +: WIDTH];
            default: w_lane = 'x;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q     <= '0;
            r_out_valid <= 1'b0;
        end else if (en) begin
            r_out_q     <= w_lane;
            r_out_valid <= 1'b1;
        end
    end

    assign out       = w_lane;
    assign out_q     = r_out_q;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux4_1_sync.sv
// tb/tb_mux4_1_sync.sv - self-checking bench for mux4_1_sync at WIDTH=1 and WIDTH=8
module tb_mux4_1_sync;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  sel;
    logic [3:0]  in1;
    logic [31:0] in8;
    logic        out1, out_q1, valid1;
    logic [7:0]  out8, out_q8;
    logic        valid8;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    logic        m_q1, m_v1, m_v8;
    logic [7:0]  m_q8;

    mux4_1_sync #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .in(in1),
        .out(out1), .out_q(out_q1), .out_valid(valid1)
    );

    mux4_1_sync #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .in(in8),
        .out(out8), .out_q(out_q8), .out_valid(valid8)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lane(input logic [31:0] v, input int s, input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (v >> (s * w)) & mask;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference for the registered path: last lane value seen on an enabled edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q1 <= 1'b0; m_v1 <= 1'b0;
            m_q8 <= 8'h00; m_v8 <= 1'b0;
        end else if (en) begin
            m_q1 <= lane({28'd0, in1}, int'(sel), 1) != 0;
            m_v1 <= 1'b1;
            m_q8 <= lane(in8, int'(sel), 8);
            m_v8 <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_out1",   {31'd0, out1},   lane({28'd0, in1}, int'(sel), 1));
            chk("cyc_outq1",  {31'd0, out_q1}, {31'd0, m_q1});
            chk("cyc_valid1", {31'd0, valid1}, {31'd0, m_v1});
            chk("cyc_out8",   {24'd0, out8},   lane(in8, int'(sel), 8));
            chk("cyc_outq8",  {24'd0, out_q8}, {24'd0, m_q8});
            chk("cyc_valid8", {31'd0, valid8}, {31'd0, m_v8});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] v;
        rst = 1; en = 0; sel = 2'b00; in1 = 4'b0000; in8 = 32'h0;
        tick(); tick();
        chk("rst_outq1",  {31'd0, out_q1}, 32'd0);
        chk("rst_valid1", {31'd0, valid1}, 32'd0);
        chk("rst_outq8",  {24'd0, out_q8}, 32'd0);
        chk("rst_valid8", {31'd0, valid8}, 32'd0);
        rst = 0;
        tick();
        cmp_en = 1;

        in1 = 4'b0000; sel = 2'b00; #1;
        chk("tp1_out", {31'd0, out1}, 32'd0);
        en = 1; tick();
        chk("tp1_outq",  {31'd0, out_q1}, 32'd0);
        chk("tp1_valid", {31'd0, valid1}, 32'd1);

        in1 = 4'b0011; sel = 2'b01; #1;
        chk("tp2_out", {31'd0, out1}, 32'd1);
        tick();
        chk("tp2_outq", {31'd0, out_q1}, 32'd1);

        in1 = 4'b0000; sel = 2'b10; #1;
        chk("tp3_out_a", {31'd0, out1}, 32'd0);
        in1 = 4'b1001; sel = 2'b11; #1;
        chk("tp3_out_b", {31'd0, out1}, 32'd1);
        tick();
        chk("tp3_outq", {31'd0, out_q1}, 32'd1);

        en = 0;
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < 4; s++) begin
                v = 4'(i);
                in1 = v; sel = 2'(s); #1;
                chk("exh_out1", {31'd0, out1}, {31'd0, v[s]});
            end
        end
        tick();

        in8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        sel = 2'd0; #1; chk("w8_sel0", {24'd0, out8}, 32'hAA);
        sel = 2'd1; #1; chk("w8_sel1", {24'd0, out8}, 32'hBB);
        sel = 2'd2; #1; chk("w8_sel2", {24'd0, out8}, 32'hCC);
        sel = 2'd3; #1; chk("w8_sel3", {24'd0, out8}, 32'hDD);
        sel = 2'd2; en = 1; tick();
        chk("w8_cap", {24'd0, out_q8}, 32'hCC);
        en = 0; sel = 2'd0; tick(); tick();
        chk("w8_hold", {24'd0, out_q8}, 32'hCC);
        chk("w8_hold_valid", {31'd0, valid8}, 32'd1);

        @(negedge clk); #2;
        rst = 1; #1;
        chk("arst_outq8",  {24'd0, out_q8}, 32'd0);
        chk("arst_valid8", {31'd0, valid8}, 32'd0);
        chk("arst_valid1", {31'd0, valid1}, 32'd0);
        sel = 2'd3; #1;
        chk("arst_out_live", {24'd0, out8}, 32'hDD);
        en = 1; tick();
        chk("arst_edge_outq8", {24'd0, out_q8}, 32'd0);
        chk("arst_edge_valid", {31'd0, valid8}, 32'd0);
        rst = 0; sel = 2'd1; tick();
        chk("reload_outq8", {24'd0, out_q8}, 32'hBB);
        chk("reload_valid", {31'd0, valid8}, 32'd1);
        en = 0; tick(); tick();

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux4_1_sync.md
Name: mux4_1_sync

Overview:
- 4-to-1 multiplexer: selects one of four input lanes using a 2-bit select.
- Provides both a combinational output and a registered output.
- Intended as a selection primitive in datapaths that need either a zero-latency path or a timing-friendly pipelined path.
- WIDTH=1 gives the classic single-bit 4:1 mux: out = in[sel].

Parameters:
- WIDTH, 1, bit width of each input lane and of each output.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  asynchronous, active-high reset; clears all registered state.
- en  input  1  capture enable for the registered output.
- sel  input  2  lane select: 0 to 3.
- in  input  4*WIDTH  packed lanes; lane k occupies bits [k*WIDTH +: WIDTH]. Lane 0 is the LSBs.
- out  output  WIDTH  combinational selected lane.
- out_q  output  WIDTH  registered selected lane.
- out_valid  output  1  high when out_q holds a captured value.

Behaviour:
- Combinational path:
  - out = lane[sel] at all times, with zero latency.
  - out ignores clk, rst and en.
  - Purely combinational: no latches; every sel value is decoded.
- Select mapping:
  - sel=2'b00 selects lane 0; 01 selects lane 1; 10 selects lane 2; 11 selects lane 3.
  - sel bit 1 is the MSB.
- X handling:
  - If sel contains X/Z, out is X in simulation.
  - Synthesis is unconstrained for X/Z select.
- Registered path:
  - On a rising clk edge with rst=0 and en=1: out_q <= lane[sel] (the same value as out), and out_valid <= 1.
  - On a rising clk edge with en=0: out_q and out_valid hold their values.
  - Latency: out_q reflects the inputs sampled at the capturing edge, one cycle after they are presented.
- Reset:
  - rst=1 immediately (asynchronously) forces out_q=0 and out_valid=0, independent of clk.
  - While rst=1, clock edges have no effect.
  - Deassertion takes effect at the next rising clk edge.
  - Reset mid-operation discards the held value. out remains live during reset.
- Simultaneous events:
  - If sel/in change in the same cycle as a capture edge, the value sampled at the edge (pre-edge settled value) is captured.
- Width rules:
  - No arithmetic and no truncation; lane width equals output width.
  - WIDTH must be at least 1.

Test Plan:
- WIDTH=1, in=4'b0000, sel=2'b00 -> out=0. After an en=1 edge -> out_q=0, out_valid=1.
- WIDTH=1, in=4'b0011, sel=2'b01 -> out=1 (lane 1). After an en=1 edge -> out_q=1.
- WIDTH=1, in=4'b0000, sel=2'b10 -> out=0. Then in=4'b1001, sel=2'b11 -> out=1 (lane 3). After an en=1 edge -> out_q=1.
- Exhaustive WIDTH=1: all 16 in values x 4 sel values -> out == in[sel] every time.
- WIDTH=8, in={8'hDD,8'hCC,8'hBB,8'hAA}:
  - sel=0 to 3 -> out = AA, BB, CC, DD respectively.
  - Capture with en=1 at sel=2 -> out_q=CC.
  - Change sel with en=0 -> out_q stays CC.
- Async reset: with out_q=CC and out_valid=1, assert rst between clock edges -> out_q=0 and out_valid=0 immediately. out still follows sel. After release, the first en=1 edge reloads.
